jt1943_snd_i2s: RTL and testbench

//  Audio output stage. It sits directly downstream of the 1943 sound board mixer
//  and consumes its signed 16-bit mono mix (snd).
//  It applies a 4-bit volume with saturation, then serialises each sample as stereo
//  I2S (L=R) for an external DAC. Optionally it also drives a 1-bit sigma-delta pin.

---
 rtl/jt1943_snd_pkg.sv | 43 ++++
 rtl/jt1943_snd_sat.sv | 72 +++++++
 rtl/jt1943_snd_i2s.sv | 122 ++++++++++++
 tb/tb_jt1943_snd_i2s.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jt1943_snd_pkg.sv
// ============================================================================
//  Module   : jt1943_snd_pkg
//  Purpose  : Shared widths, saturation limits and helpers for the 1943 audio
//             output stage (I2S serialiser and optional sigma-delta pin).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package jt1943_snd_pkg;

  localparam int SW         = 16;
  localparam int FRAME_BITS = 32;
  localparam int VOL_FRAC   = 3;
  localparam int VW         = 4;
  localparam int PW         = SW + VW + 1;
  localparam int BW         = $clog2(FRAME_BITS);

  localparam logic [SW-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [SW-1:0] SAT_MIN = 16'h8000;

  // lrck is high for bit indices LRCK_FIRST..LRCK_LAST, one bclk ahead of the right word
  localparam int LRCK_FIRST = FRAME_BITS / 2 - 1;
  localparam int LRCK_LAST  = FRAME_BITS - 2;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_POS  = 2'd1,
    SAT_NEG  = 2'd2
  } sat_kind_e;

  // A scaled value fits in SW bits only when its bits [PW-1:SW-1] are all equal
  function automatic sat_kind_e sat_classify(input logic [PW-1:0] v);
    logic [PW-SW:0] top;
    top = v[PW-1:SW-1];
    if (top == '0 || top == '1) begin
      return SAT_NONE;
    end
    return v[PW-1] ? SAT_NEG : SAT_POS;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jt1943_snd_sat.sv
// ============================================================================
//  Module   : jt1943_snd_sat
//  Purpose  : Two-stage volume pipeline: multiply by vol/8, saturate to 16 bits
//             and mute. sat_o flags the cycle stage 2 clamps a sample.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jt1943_snd_sat
  import jt1943_snd_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] snd_i,
  input  logic [VW-1:0] vol_i,
  input  logic          enable_i,
  output logic [SW-1:0] proc_o,
  output logic          sat_o
);

  logic signed [PW-1:0] w_snd_ext;
  logic signed [PW-1:0] w_vol_ext;
  logic signed [PW-1:0] w_prod;

  logic signed [PW-1:0] prod_q, prod_d;
  logic [SW-1:0]        proc_q, proc_d;
  sat_kind_e            w_kind;
  logic                 w_sat;

  assign w_snd_ext = {{(PW-SW){snd_i[SW-1]}}, snd_i};
  assign w_vol_ext = {{(PW-VW){1'b0}}, vol_i};
  assign w_prod    = w_snd_ext * w_vol_ext;
  assign prod_d    = w_prod >>> VOL_FRAC;

  always_comb begin
    w_kind = sat_classify(prod_q);
    proc_d = prod_q[SW-1:0];
    w_sat  = 1'b0;
    if (!enable_i) begin
      proc_d = '0;
    end else begin
      case (w_kind)
        SAT_POS: begin
          proc_d = SAT_MAX;
          w_sat  = 1'b1;
        end
        SAT_NEG: begin
          proc_d = SAT_MIN;
          w_sat  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      proc_q <= '0;
    end else begin
      prod_q <= prod_d;
      proc_q <= proc_d;
    end
  end

  assign proc_o = proc_q;
  // Asserted in the same cycle the clamped value is written into proc
  assign sat_o  = w_sat;

endmodule

`default_nettype wire

// File: rtl/jt1943_snd_i2s.sv
// ============================================================================
//  Module   : jt1943_snd_i2s
//  Purpose  : 1943 audio output stage: volume/saturation, stereo I2S (L=R)
//             serialiser, sticky clip flag and optional 1-bit sigma-delta pin.
//  Options  : JT1943_SND_PDM_EN - build the sigma-delta accumulator on pdm.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jt1943_snd_i2s
  import jt1943_snd_pkg::*;
#(
  parameter int BCLK_DIV = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] snd,
  input  logic          enable,
  input  logic [VW-1:0] vol,
  input  logic          clip_clr,
  output logic          i2s_bclk,
  output logic          i2s_lrck,
  output logic          i2s_data,
  output logic          sample_stb,
  output logic          clip,
  output logic          pdm
);

  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [SW-1:0] w_proc;
  logic          w_sat;

  jt1943_snd_sat u_sat (
    .clk      (clk),
    .rst      (rst),
    .snd_i    (snd),
    .vol_i    (vol),
    .enable_i (enable),
    .proc_o   (w_proc),
    .sat_o    (w_sat)
  );

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  bclk_q, bclk_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  stb_q, stb_d;
  logic                  clip_q, clip_d;
  logic                  w_wrap;
  logic                  w_fall;

  assign w_wrap = (cnt_q == CW'(BCLK_DIV - 1));
  assign w_fall = w_wrap & bclk_q;

  always_comb begin
    cnt_d   = w_wrap ? '0 : cnt_q + CW'(1);
    bclk_d  = bclk_q ^ w_wrap;
    bit_d   = bit_q;
    shift_d = shift_q;
    stb_d   = 1'b0;
    if (w_fall) begin
      bit_d = bit_q + BW'(1);
      // Last bit of the frame: the next falling edge starts a fresh sample
      if (bit_q == BW'(FRAME_BITS - 1)) begin
        shift_d = {w_proc, w_proc};
        stb_d   = 1'b1;
      end else begin
        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  // A coincident saturation outranks a clear request
  assign clip_d = w_sat | (clip_q & ~clip_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      bclk_q  <= 1'b0;
      bit_q   <= BW'(FRAME_BITS - 1);
      shift_q <= '0;
      stb_q   <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bclk_q  <= bclk_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      stb_q   <= stb_d;
      clip_q  <= clip_d;
    end
  end

  assign i2s_bclk   = bclk_q;
  assign i2s_data   = shift_q[FRAME_BITS-1];
  assign i2s_lrck   = (bit_q >= BW'(LRCK_FIRST)) && (bit_q <= BW'(LRCK_LAST));
  assign sample_stb = stb_q;
  assign clip       = clip_q;

`ifdef JT1943_SND_PDM_EN
  logic [SW:0] acc_q, acc_d;

  // Offset-binary input turns the carry rate into (proc + 32768) / 65536
  assign acc_d = {1'b0, acc_q[SW-1:0]} + {1'b0, w_proc ^ SAT_MIN};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign pdm = acc_q[SW];
`else
  assign pdm = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jt1943_snd_i2s.sv
// ============================================================================
//  Module   : tb_jt1943_snd_i2s
//  Purpose  : Self-checking bench for jt1943_snd_i2s: per-cycle reference
//             model plus directed frame captures and randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jt1943_snd_i2s;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic [15:0] snd      = 16'h0000;
  logic        enable   = 1'b1;
  logic [3:0]  vol      = 4'd8;
  logic        clip_clr = 1'b0;
  logic        i2s_bclk, i2s_lrck, i2s_data, sample_stb, clip, pdm;

  always #5 clk = ~clk;

  jt1943_snd_i2s #(.BCLK_DIV(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .snd        (snd),
    .enable     (enable),
    .vol        (vol),
    .clip_clr   (clip_clr),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrck   (i2s_lrck),
    .i2s_data   (i2s_data),
    .sample_stb (sample_stb),
    .clip       (clip),
    .pdm        (pdm)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: edges since release, frame index arithmetic, plain integers
  int          e_m, b_m, p_m, proc_m, old_proc_m, s_m, acc_m;
  logic [31:0] word_m;
  logic        stb_m, clip_m, sat_m;
  logic        bclk_m, lrck_m, data_m, pdm_m;
  logic [5:0]  exp_v, act_v;

  initial begin
    e_m = 0; b_m = 31; p_m = 0; proc_m = 0; acc_m = 0;
    word_m = 0; stb_m = 0; clip_m = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        e_m = 0; b_m = 31; p_m = 0; proc_m = 0; acc_m = 0;
        word_m = 0; stb_m = 0; clip_m = 0;
      end else begin
        old_proc_m = proc_m;
        acc_m = (acc_m % 65536) + ((old_proc_m & 32'hFFFF) ^ 32'h8000);
        s_m   = p_m >>> 3;
        sat_m = 1'b0;
        if (!enable) proc_m = 0;
        else if (s_m > 32767) begin proc_m = 32767; sat_m = 1'b1; end
        else if (s_m < -32768) begin proc_m = -32768; sat_m = 1'b1; end
        else proc_m = s_m;
        p_m = int'($signed(snd)) * int'(vol);
        if (sat_m) clip_m = 1'b1;
        else if (clip_clr) clip_m = 1'b0;
        e_m   = e_m + 1;
        stb_m = 1'b0;
        if (e_m % 16 == 0) begin
          b_m = (b_m + 1) % 32;
          if (b_m == 0) begin
            word_m = {old_proc_m[15:0], old_proc_m[15:0]};
            stb_m  = 1'b1;
          end
        end
      end
      bclk_m = ((e_m / 8) % 2) == 1;
      lrck_m = (b_m >= 15) && (b_m <= 30);
      data_m = word_m[31 - b_m];
`ifdef JT1943_SND_PDM_EN
      pdm_m = (acc_m >= 65536);
`else
      pdm_m = 1'b0;
`endif
      exp_v = {bclk_m, lrck_m, data_m, stb_m, clip_m, pdm_m};
      act_v = {i2s_bclk, i2s_lrck, i2s_data, sample_stb, clip, pdm};
      vectors = vectors + 1;
      if (act_v !== exp_v) begin
        miscompares = miscompares + 1;
        $display("FAIL cycle t=%0t {bclk,lrck,data,stb,clip,pdm} got=%b exp=%b",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for the next frame load, then samples data/lrck on each bclk rise
  task automatic capture(output logic [31:0] dw, output logic [31:0] lw);
    int   guard;
    logic prev;
    dw = '0;
    lw = '0;
    guard = 0;
    while (!sample_stb && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("stb_seen", {31'd0, sample_stb}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      guard = 0;
      do begin
        prev = i2s_bclk;
        @(negedge clk);
        guard++;
      end while (!(i2s_bclk && !prev) && guard < 40);
      dw = {dw[30:0], i2s_data};
      lw = {lw[30:0], i2s_lrck};
    end
  endtask

  task automatic stb_latency(output int n);
    n = 0;
    while (!sample_stb && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  logic [31:0] dw, lw;
  int          n, ones, guard;

  initial begin
    // Unity gain from reset
    snd = 16'h1234; vol = 4'd8; enable = 1'b1;
    tick(4);
    check("reset_outputs", {26'd0, i2s_bclk, i2s_lrck, i2s_data, sample_stb, clip, pdm}, 32'd0);
    rst = 1'b0;
    stb_latency(n);
    check("first_stb_edge", n, 32'd16);
    capture(dw, lw);
    check("unity_word", dw, 32'h1234_1234);
    check("unity_lrck", lw, 32'h0001_FFFE);

    // Positive overflow and clear
    snd = 16'h7000; vol = 4'd15;
    tick(4);
    capture(dw, lw);
    check("pos_sat_word", dw, 32'h7FFF_7FFF);
    check("pos_sat_clip", {31'd0, clip}, 32'd1);
    snd = 16'h0000;
    tick(4);
    clip_clr = 1'b1;
    tick(1);
    check("clip_cleared", {31'd0, clip}, 32'd0);
    clip_clr = 1'b0;

    // Negative overflow, then in-range negative
    snd = 16'h8000; vol = 4'd15;
    tick(4);
    capture(dw, lw);
    check("neg_sat_word", dw, 32'h8000_8000);
    check("neg_sat_clip", {31'd0, clip}, 32'd1);
    vol = 4'd4;
    tick(4);
    clip_clr = 1'b1;
    tick(1);
    clip_clr = 1'b0;
    capture(dw, lw);
    check("neg_half_word", dw, 32'hC000_C000);
    check("neg_half_clip", {31'd0, clip}, 32'd0);

    // Mute
    enable = 1'b0; snd = 16'h7FFF; vol = 4'd8;
    tick(4);
    capture(dw, lw);
    check("mute_word", dw, 32'h0000_0000);
    capture(dw, lw);
    check("mute_word2", dw, 32'h0000_0000);
    check("mute_clip", {31'd0, clip}, 32'd0);

    // Reset in the middle of a frame
    enable = 1'b1; snd = 16'h5A5A; vol = 4'd8;
    guard = 0;
    while (b_m != 10 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_bit10", b_m, 32'd10);
    rst = 1'b1;
    tick(1);
    check("midframe_reset", {26'd0, i2s_bclk, i2s_lrck, i2s_data, sample_stb, clip, pdm}, 32'd0);
    tick(2);
    rst = 1'b0;
    stb_latency(n);
    check("restart_stb_edge", n, 32'd16);
    capture(dw, lw);
    check("restart_word", dw, 32'h5A5A_5A5A);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) snd = 16'($urandom);
      if ($urandom_range(0, 31) == 0) vol = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) enable = ($urandom_range(0, 9) != 0);
      clip_clr = ($urandom_range(0, 19) == 0);
    end
    clip_clr = 1'b0;
    enable = 1'b1;

`ifdef JT1943_SND_PDM_EN
    snd = 16'h0000; vol = 4'd8;
    tick(4);
    ones = 0;
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      if (pdm) ones++;
    end
    check("pdm_half_ones", ones, 32'd32768);
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
